// File: rtl/reg_file.sv
// reg_file: architectural register file with destination/writeback select.
// Ports: clk, rst_n (async, active low); RegWrite/RegDst/MemtoReg controls;
//   A1/A2/A3 register indices; ALUResult/ReadData writeback sources;
//   RD1/RD2 combinational operands; WriteReg/Result selected destination/value.
// Config: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic                  RegDst,
  input  logic                  MemtoReg,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] ReadData,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [ADDR_WIDTH-1:0] WriteReg,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_en;

  assign WriteReg = RegDst ? A3 : A2;
  assign Result   = MemtoReg ? ReadData : ALUResult;

  // rst_n gates the enable so a held reset also blocks forwarding.
  assign wr_en = rst_n && RegWrite && (WriteReg != '0);

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[WriteReg] <= Result;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] d;
    d = regs_q[a];
    if (a == '0) begin
      d = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && (a == WriteReg)) begin
      d = Result;
    end
`endif
    return d;
  endfunction

  always_comb begin
    RD1 = rd_port(A1);
    RD2 = rd_port(A2);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: random and directed checks of reg_file against an
// array-based model of the architectural registers.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          RegWrite, RegDst, MemtoReg;
  logic [AW-1:0] A1, A2, A3;
  logic [DW-1:0] ALUResult, ReadData;
  logic [DW-1:0] RD1, RD2, Result;
  logic [AW-1:0] WriteReg;

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .A1(A1), .A2(A2), .A3(A3),
    .ALUResult(ALUResult), .ReadData(ReadData),
    .RD1(RD1), .RD2(RD2),
    .WriteReg(WriteReg), .Result(Result)
  );

  logic [DW-1:0] mdl [N];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_wr();
    return RegDst ? int'(A3) : int'(A2);
  endfunction

  function automatic logic [DW-1:0] exp_res();
    return MemtoReg ? ReadData : ALUResult;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (!rst_n || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && exp_wr() != 0 && a == exp_wr()) return exp_res();
`endif
    return mdl[a];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".wreg"}, DW'(WriteReg), DW'(exp_wr()));
    chk({tag, ".res"}, Result, exp_res());
    chk({tag, ".rd1"}, RD1, exp_rd(int'(A1)));
    chk({tag, ".rd2"}, RD2, exp_rd(int'(A2)));
  endtask

  task automatic drive(input logic rst, input logic we, input logic dst,
                       input logic m2r, input int a1, input int a2,
                       input int a3, input logic [DW-1:0] alu,
                       input logic [DW-1:0] rdat, input string tag);
    @(negedge clk);
    rst_n = rst; RegWrite = we; RegDst = dst; MemtoReg = m2r;
    A1 = AW'(a1); A2 = AW'(a2); A3 = AW'(a3);
    ALUResult = alu; ReadData = rdat;
    if (!rst) foreach (mdl[i]) mdl[i] = '0;
    #1 check_all({tag, ".pre"});
  endtask

  task automatic commit(input string tag);
    @(posedge clk);
    if (rst_n && RegWrite && exp_wr() != 0) mdl[exp_wr()] = exp_res();
    #1 check_all({tag, ".post"});
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    rst_n = 1'b0; RegWrite = 1'b1; RegDst = 1'b1; MemtoReg = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; ALUResult = '1; ReadData = '1;

    // reset sweep with a pending write that must not show or land
    for (int a = 0; a < N; a++) begin
      A1 = AW'(a); A2 = AW'(N - 1 - a); A3 = AW'(a);
      #1;
      chk("rst.rd1", RD1, '0);
      chk("rst.rd2", RD2, '0);
    end
    commit("rst_edge");

    // first write lands on the first edge after release
    drive(1, 1, 1, 0, 5, 0, 5, 32'hDEADBEEF, 0, "rel");
    commit("rel");
    drive(1, 0, 1, 0, 5, 5, 7, 0, 0, "r5");
    chk("r5.rd1", RD1, 32'hDEADBEEF);

    // asynchronous clear mid-cycle
    #2 rst_n = 1'b0;
    foreach (mdl[i]) mdl[i] = '0;
    #1 chk("async.rd1", RD1, '0);

    // reset coinciding with a write edge wins
    drive(0, 1, 1, 0, 6, 6, 6, 32'h1, 0, "rstw");
    commit("rstw");
    chk("rstw.rd1", RD1, '0);

    // R-type: rd gets ALUResult, rt untouched
    drive(1, 1, 1, 0, 3, 0, 3, 32'h0BADF00D, 0, "pre3");
    commit("pre3");
    drive(1, 1, 1, 0, 8, 3, 8, 32'h00001234, 32'h99, "rtype");
    commit("rtype");
    chk("rtype.rd1", RD1, 32'h00001234);
    chk("rtype.rd2", RD2, 32'h0BADF00D);

    // load: rt gets ReadData
    drive(1, 1, 0, 1, 9, 9, 4, 32'h77, 32'hCAFEF00D, "load");
    chk("load.wreg", DW'(WriteReg), 32'd9);
    chk("load.res", Result, 32'hCAFEF00D);
    commit("load");
    chk("load.rd1", RD1, 32'hCAFEF00D);

    // zero register discards writes
    drive(1, 1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 0, "zero");
    commit("zero");
    chk("zero.rd1", RD1, '0);

    // write disabled for three edges
    drive(1, 1, 1, 0, 10, 10, 10, 32'hA5A5, 0, "pre10");
    commit("pre10");
    drive(1, 0, 1, 0, 10, 10, 10, 32'h55, 0, "wdis");
    for (int k = 0; k < 3; k++) commit("wdis");
    chk("wdis.rd1", RD1, 32'hA5A5);

    // read-during-write on reg12
    drive(1, 1, 1, 0, 0, 0, 12, 32'h11, 0, "pre12");
    commit("pre12");
    drive(1, 1, 1, 0, 12, 12, 12, 32'h22, 0, "raw");
`ifdef REGFILE_BYPASS_EN
    chk("raw.pre_rd1", RD1, 32'h22);
    chk("raw.pre_rd2", RD2, 32'h22);
`else
    chk("raw.pre_rd1", RD1, 32'h11);
    chk("raw.pre_rd2", RD2, 32'h11);
`endif
    commit("raw");
    chk("raw.post_rd1", RD1, 32'h22);
    chk("raw.post_rd2", RD2, 32'h22);

    // random traffic, occasionally hitting the write index and reset
    for (int it = 0; it < 500; it++) begin
      int w3, w2;
      w3 = int'($urandom_range(0, N - 1));
      w2 = int'($urandom_range(0, N - 1));
      drive(($urandom_range(0, 40) != 0), $urandom_range(0, 3) != 0,
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? w3 : int'($urandom_range(0, N - 1)),
            w2, w3, $urandom, $urandom, "rnd");
      commit("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
